// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program-counter generator.
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    PendNone  = 2'd0,
    PendRedir = 2'd1,
    PendTrap  = 2'd2
  } pend_kind_e;

endpackage

// File: rtl/pc_generator_if.sv
// Control/status bundle between the pipeline (master) and the PC generator (slave).
interface pc_generator_if
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            busyWait;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] PC;
  logic            pc_valid;
  logic [XLEN-1:0] pc_plus_step;
  logic            misalign_err;

  modport master (
    output busyWait, redirect_valid, redirect_target, trap_valid,
    input  PC, pc_valid, pc_plus_step, misalign_err
  );

  modport slave (
    input  busyWait, redirect_valid, redirect_target, trap_valid,
    output PC, pc_valid, pc_plus_step, misalign_err
  );

endinterface

// File: rtl/pc_pending_slot.sv
// Holds a redirect or trap that arrived during a memory freeze, with trap-over-redirect
// overwrite priority. A consumed slot can be reloaded on the same edge.
module pc_pending_slot
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_capture_en,
  input  logic            i_consume,
  input  logic            i_trap,
  input  logic            i_redir,
  input  logic [XLEN-1:0] i_target,
  output pend_kind_e      o_kind,
  output logic [XLEN-1:0] o_target,
  output logic            o_redir_accept
);

  pend_kind_e      r_kind;
  pend_kind_e      w_kind_next;
  pend_kind_e      w_base_kind;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_next;

  // A slot being drained this edge no longer blocks a fresh redirect.
  assign w_base_kind = i_consume ? PendNone : r_kind;

  always_comb begin
    w_kind_next    = w_base_kind;
    w_target_next  = r_target;
    o_redir_accept = 1'b0;
    if (i_capture_en) begin
      if (i_trap) begin
        w_kind_next   = PendTrap;
        w_target_next = TRAP_VECTOR;
      end else if (i_redir && (w_base_kind != PendTrap)) begin
        w_kind_next    = PendRedir;
        w_target_next  = i_target;
        o_redir_accept = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kind   <= PendNone;
      r_target <= '0;
    end else begin
      r_kind   <= w_kind_next;
      r_target <= w_target_next;
    end
  end

  assign o_kind   = r_kind;
  assign o_target = r_target;

endmodule

// File: rtl/pc_generator.sv
// IF-stage program counter: sequential step, redirect/trap with fixed priority,
// freeze under busyWait with a pending slot for requests seen while frozen.
module pc_generator
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int unsigned     STEP         = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  pc_generator_if.slave  bus
);

  localparam logic [XLEN-1:0] LowMask = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] StepInc = XLEN'(STEP);

  pc_state_e       r_state;
  pc_state_e       w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_pc_valid;
  logic            r_misalign;
  logic            w_misalign_next;
  logic [XLEN-1:0] w_redir_aligned;
  logic            w_req;
  logic            w_capture_en;
  logic            w_consume;
  logic            w_run_redir;
  logic            w_slot_redir_accept;
  pend_kind_e      w_pend_kind;
  logic [XLEN-1:0] w_pend_target;

  assign w_redir_aligned = bus.redirect_target & ~LowMask;
  assign w_req           = bus.trap_valid | bus.redirect_valid;
  assign w_capture_en    = ((r_state == StRun) && bus.busyWait) || (r_state == StPend);
  assign w_consume       = (r_state == StPend) && !bus.busyWait;
  assign w_run_redir     = (r_state == StRun) && !bus.busyWait && !bus.trap_valid &&
                           bus.redirect_valid;
  assign w_misalign_next = (w_run_redir | w_slot_redir_accept) &&
                           ((bus.redirect_target & LowMask) != '0);

  pc_pending_slot #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pending_slot (
    .i_clk          (CLK),
    .i_rst          (RESET),
    .i_capture_en   (w_capture_en),
    .i_consume      (w_consume),
    .i_trap         (bus.trap_valid),
    .i_redir        (bus.redirect_valid),
    .i_target       (w_redir_aligned),
    .o_kind         (w_pend_kind),
    .o_target       (w_pend_target),
    .o_redir_accept (w_slot_redir_accept)
  );

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    unique case (r_state)
      StBoot: w_state_next = StRun;
      StRun: begin
        if (bus.busyWait) begin
          if (w_req) w_state_next = StPend;
        end else if (bus.trap_valid) begin
          w_pc_next = TRAP_VECTOR;
        end else if (bus.redirect_valid) begin
          w_pc_next = w_redir_aligned;
        end else begin
          w_pc_next = r_pc + StepInc;
        end
      end
      StPend: begin
        // Release: apply the slot; a request on the same edge keeps us here one more cycle.
        if (!bus.busyWait) begin
          if (w_pend_kind != PendNone) w_pc_next = w_pend_target;
          if (!w_req) w_state_next = StRun;
        end
      end
      default: w_state_next = StBoot;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= StBoot;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_pc_valid <= 1'b1;
      r_misalign <= w_misalign_next;
    end
  end

  assign bus.PC           = r_pc;
  assign bus.pc_valid     = r_pc_valid;
  assign bus.pc_plus_step = r_pc + StepInc;
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_generator.sv
// Directed bench for pc_generator: expectations queued at drive time, checked after the edge.
module tb_pc_generator;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  pc_generator_if #(.XLEN(32)) u_if ();

  pc_generator #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .STEP         (4)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (u_if)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic busy, input logic rv,
                      input logic [31:0] tgt, input logic tv, input logic [31:0] epc,
                      input logic evalid, input logic emis);
    exp_t e;
    exp_t got;
    RESET                  = rst;
    u_if.busyWait          = busy;
    u_if.redirect_valid    = rv;
    u_if.redirect_target   = tgt;
    u_if.trap_valid        = tv;
    e.tag   = tag;
    e.pc    = epc;
    e.valid = evalid;
    e.mis   = emis;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".pc"},    u_if.PC,                    got.pc);
    chk({got.tag, ".valid"}, {31'd0, u_if.pc_valid},     {31'd0, got.valid});
    chk({got.tag, ".mis"},   {31'd0, u_if.misalign_err}, {31'd0, got.mis});
    chk({got.tag, ".plus"},  u_if.pc_plus_step,          got.pc + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    u_if.busyWait        = 1'b0;
    u_if.redirect_valid  = 1'b0;
    u_if.redirect_target = '0;
    u_if.trap_valid      = 1'b0;

    // tag, rst, busy, rv, target, tv, exp_pc, exp_valid, exp_mis
    step("rst0",   1, 0, 0, 32'h0,   0, 32'h0,   0, 0);
    step("rst1",   1, 0, 0, 32'h0,   0, 32'h0,   0, 0);
    step("boot",   0, 0, 0, 32'h0,   0, 32'h0,   1, 0);
    step("seq4",   0, 0, 0, 32'h0,   0, 32'h4,   1, 0);
    step("seq8",   0, 0, 0, 32'h0,   0, 32'h8,   1, 0);
    step("seqC",   0, 0, 0, 32'h0,   0, 32'hC,   1, 0);
    step("seq10",  0, 0, 0, 32'h0,   0, 32'h10,  1, 0);
    step("rd200",  0, 0, 1, 32'h200, 0, 32'h200, 1, 0);
    step("rd204",  0, 0, 0, 32'h0,   0, 32'h204, 1, 0);
    step("rd303",  0, 0, 1, 32'h303, 0, 32'h300, 1, 1);
    step("rd304",  0, 0, 0, 32'h0,   0, 32'h304, 1, 0);

    // Frozen redirect
    step("to40",   0, 0, 1, 32'h40,  0, 32'h40,  1, 0);
    step("frz1",   0, 1, 1, 32'h80,  0, 32'h40,  1, 0);
    step("frz2",   0, 1, 0, 32'h0,   0, 32'h40,  1, 0);
    step("frz3",   0, 1, 0, 32'h0,   0, 32'h40,  1, 0);
    step("frzrel", 0, 0, 0, 32'h0,   0, 32'h80,  1, 0);
    step("frz84",  0, 0, 0, 32'h0,   0, 32'h84,  1, 0);

    // Pending priority: trap then redirect
    step("p1trap", 0, 1, 0, 32'h0,   1, 32'h84,  1, 0);
    step("p1rd",   0, 1, 1, 32'h500, 0, 32'h84,  1, 0);
    step("p1rel",  0, 0, 0, 32'h0,   0, 32'h100, 1, 0);
    step("p1seq",  0, 0, 0, 32'h0,   0, 32'h104, 1, 0);
    // redirect then trap
    step("p2rd",   0, 1, 1, 32'h500, 0, 32'h104, 1, 0);
    step("p2trap", 0, 1, 0, 32'h0,   1, 32'h104, 1, 0);
    step("p2rel",  0, 0, 0, 32'h0,   0, 32'h100, 1, 0);
    step("p2seq",  0, 0, 0, 32'h0,   0, 32'h104, 1, 0);
    // redirect then redirect
    step("p3rd5",  0, 1, 1, 32'h500, 0, 32'h104, 1, 0);
    step("p3rd6",  0, 1, 1, 32'h600, 0, 32'h104, 1, 0);
    step("p3rel",  0, 0, 0, 32'h0,   0, 32'h600, 1, 0);
    step("p3seq",  0, 0, 0, 32'h0,   0, 32'h604, 1, 0);

    step("simul",  0, 0, 1, 32'h500, 1, 32'h100, 1, 0);

    // Release edge with a new redirect: applied one edge later
    step("rn_cap", 0, 1, 1, 32'h500, 0, 32'h100, 1, 0);
    step("rn_rel", 0, 0, 1, 32'h700, 0, 32'h500, 1, 0);
    step("rn_new", 0, 0, 0, 32'h0,   0, 32'h700, 1, 0);
    step("rn_seq", 0, 0, 0, 32'h0,   0, 32'h704, 1, 0);

    // Misaligned pending redirect pulses on capture
    step("pm_cap", 0, 1, 1, 32'h802, 0, 32'h704, 1, 1);
    step("pm_rel", 0, 0, 0, 32'h0,   0, 32'h800, 1, 0);

    // Wrap-around
    step("wr_f8",  0, 0, 1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 1, 0);
    step("wr_fc",  0, 0, 0, 32'h0,   0, 32'hFFFF_FFFC, 1, 0);
    step("wr_0",   0, 0, 0, 32'h0,   0, 32'h0,   1, 0);
    step("wr_4",   0, 0, 0, 32'h0,   0, 32'h4,   1, 0);

    // Reset while pending discards the slot
    step("rp_cap", 0, 1, 1, 32'h900, 0, 32'h4,   1, 0);
    step("rp_hld", 0, 1, 0, 32'h0,   0, 32'h4,   1, 0);
    step("rp_rst", 1, 1, 1, 32'h900, 0, 32'h0,   0, 0);
    step("rp_bt",  0, 0, 0, 32'h0,   0, 32'h0,   1, 0);
    step("rp_s4",  0, 0, 0, 32'h0,   0, 32'h4,   1, 0);
    step("rp_s8",  0, 0, 0, 32'h0,   0, 32'h8,   1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
